// File: rtl/pwm_breath_sequencer_pkg.sv
// Shared LED PWM types: breathing phase encoding and duty width.
// Latency: n/a (types only).
// Backpressure: n/a.
package led_pwm_pkg;
    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        OFF_HOLD  = 2'b00,
        RAMP_UP   = 2'b01,
        ON_HOLD   = 2'b10,
        RAMP_DOWN = 2'b11
    } phase_t;
endpackage

// File: rtl/pwm_breath_sequencer_if.sv
// Control/status bundle between the breathing sequencer and its PWM consumer.
// Latency: n/a (wires only).
// Backpressure: none; duty is a level, cycle_done a single-clk pulse.
interface pwm_breath_sequencer_if;
    import led_pwm_pkg::*;

    logic              enable;
    logic [DUTY_W-1:0] duty_cycle;
    phase_t            phase;
    logic              cycle_done;

    modport master (input enable, output duty_cycle, output phase, output cycle_done);
    modport slave  (output enable, input duty_cycle, input phase, input cycle_done);
endinterface

// File: rtl/pwm_breath_sequencer_tick_gen.sv
// Step-tick prescaler: pulses tick once every CLK_DIV clk, synchronous clear.
// Latency: first tick CLK_DIV edges after clear drops.
// Backpressure: none; free-running while clr is low.
module tick_gen #(
    parameter logic [23:0] CLK_DIV = 24'd1_200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam logic [23:0] DIV_LAST = CLK_DIV - 24'd1;

    logic [23:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 24'd1;
        end
    end
endmodule

// File: rtl/pwm_breath_sequencer.sv
// Breathing duty sequencer: off-hold, ramp-up, on-hold, ramp-down, repeat.
// Latency: outputs registered, updated only on step-tick edges.
// Backpressure: none; enable low forces off-hold with duty 0 on the next edge.
module pwm_breath_sequencer
    import led_pwm_pkg::*;
#(
    parameter logic [23:0]       CLK_DIV    = 24'd1_200_000,
    parameter logic [DUTY_W-1:0] DUTY_MAX   = 8'd200,
    parameter logic [DUTY_W-1:0] STEP       = 8'd1,
    parameter logic [7:0]        HOLD_STEPS = 8'd50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pwm_breath_sequencer_if.master bus
);
    localparam logic [7:0] HOLD_LAST = HOLD_STEPS - 8'd1;

    logic              tick;
    phase_t            state, state_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt;
    logic [7:0]        hold_cnt, hold_nxt;
    logic              done, done_nxt;
    logic [DUTY_W:0]   sum;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.enable),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF_HOLD;
            duty     <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            hold_cnt <= hold_nxt;
            done     <= done_nxt;
        end
    end

    // Ramp sum is one bit wider so saturation is detected before any 8-bit wrap.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        sum       = {1'b0, duty} + {1'b0, STEP};
        if (!bus.enable) begin
            state_nxt = OFF_HOLD;
            duty_nxt  = '0;
            hold_nxt  = '0;
        end else if (tick) begin
            case (state)
                OFF_HOLD: begin
                    duty_nxt = '0;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt  = '0;
                        state_nxt = RAMP_UP;
                    end else begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end
                RAMP_UP: begin
                    if (sum >= {1'b0, DUTY_MAX}) begin
                        duty_nxt  = DUTY_MAX;
                        state_nxt = ON_HOLD;
                    end else begin
                        duty_nxt = sum[DUTY_W-1:0];
                    end
                end
                ON_HOLD: begin
                    duty_nxt = DUTY_MAX;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt  = '0;
                        state_nxt = RAMP_DOWN;
                    end else begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end
                default: begin
                    if (duty <= STEP) begin
                        duty_nxt  = '0;
                        state_nxt = OFF_HOLD;
                        done_nxt  = 1'b1;
                    end else begin
                        duty_nxt = duty - STEP;
                    end
                end
            endcase
        end
    end

    assign bus.duty_cycle = duty;
    assign bus.phase      = state;
    assign bus.cycle_done = done;
endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Directed bench: two sequencer instances (STEP=3 and STEP=10) checked per edge
// against hand-computed per-tick duty/phase tables.
module tb_pwm_breath_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Expected state after the Nth tick of a period (index N-1), DUTY_MAX=10, HOLD_STEPS=2.
    int d1_tab [12] = '{0, 0, 3, 6, 9, 10, 10, 10, 7, 4, 1, 0};
    int p1_tab [12] = '{0, 1, 1, 1, 1, 2,  2,  3,  3, 3, 3, 0};
    int d2_tab [6]  = '{0, 0, 10, 10, 10, 0};
    int p2_tab [6]  = '{0, 1, 2,  2,  3,  0};

    pwm_breath_sequencer_if bus1();
    pwm_breath_sequencer_if bus2();

    pwm_breath_sequencer #(
        .CLK_DIV(24'd4), .DUTY_MAX(8'd10), .STEP(8'd3), .HOLD_STEPS(8'd2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    pwm_breath_sequencer #(
        .CLK_DIV(24'd4), .DUTY_MAX(8'd10), .STEP(8'd10), .HOLD_STEPS(8'd2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_duty1"}, 32'(bus1.duty_cycle), 32'd0);
        chk({tag, "_phase1"}, 32'(bus1.phase), 32'd0);
        chk({tag, "_done1"}, 32'(bus1.cycle_done), 32'd0);
        chk({tag, "_duty2"}, 32'(bus2.duty_cycle), 32'd0);
        chk({tag, "_phase2"}, 32'(bus2.phase), 32'd0);
        chk({tag, "_done2"}, 32'(bus2.cycle_done), 32'd0);
    endtask

    // Runs nedges edges from a freshly restarted sequence, checking every edge.
    task automatic run_and_check(input int nedges);
        int   n, i1, i2;
        int   e1d, e1p, e1c, e2d, e2p, e2c;
        logic prev1, prev2;
        prev1 = 1'b0;
        prev2 = 1'b0;
        for (int k = 1; k <= nedges; k++) begin
            @(posedge clk);
            #1;
            n = k / 4;
            if (n == 0) begin
                e1d = 0; e1p = 0; e1c = 0;
                e2d = 0; e2p = 0; e2c = 0;
            end else begin
                i1  = (n - 1) % 12;
                i2  = (n - 1) % 6;
                e1d = d1_tab[i1];
                e1p = p1_tab[i1];
                e1c = ((k % 4) == 0 && i1 == 11) ? 1 : 0;
                e2d = d2_tab[i2];
                e2p = p2_tab[i2];
                e2c = ((k % 4) == 0 && i2 == 5) ? 1 : 0;
            end
            chk("duty1", 32'(bus1.duty_cycle), 32'(e1d));
            chk("phase1", 32'(bus1.phase), 32'(e1p));
            chk("done1", 32'(bus1.cycle_done), 32'(e1c));
            chk("duty2", 32'(bus2.duty_cycle), 32'(e2d));
            chk("phase2", 32'(bus2.phase), 32'(e2p));
            chk("done2", 32'(bus2.cycle_done), 32'(e2c));
            chk("duty1_le_max", 32'(bus1.duty_cycle > 8'd10), 32'd0);
            chk("duty2_le_max", 32'(bus2.duty_cycle > 8'd10), 32'd0);
            chk("done1_no_repeat", 32'(prev1 && bus1.cycle_done), 32'd0);
            chk("done2_no_repeat", 32'(prev2 && bus2.cycle_done), 32'd0);
            prev1 = bus1.cycle_done;
            prev2 = bus2.cycle_done;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus1.enable = 1'b0;
        bus2.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        bus1.enable = 1'b1;
        bus2.enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Long free run: two-phase table check plus range/pulse invariants.
        run_and_check(1000);

        // Drop enable mid-ramp-down, then restart and drop again at duty 6.
        bus1.enable = 1'b0;
        bus2.enable = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("disable_a");
        bus1.enable = 1'b1;
        bus2.enable = 1'b1;
        run_and_check(16);
        chk("duty_is_6", 32'(bus1.duty_cycle), 32'd6);
        bus1.enable = 1'b0;
        bus2.enable = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("disable_b");
        @(posedge clk);
        #1;
        chk_idle("disabled_hold");

        // Re-enable and advance into ON_HOLD, then reset between edges.
        bus1.enable = 1'b1;
        bus2.enable = 1'b1;
        run_and_check(28);
        chk("on_hold_phase", 32'(bus1.phase), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
